// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Shared icode, status and FSM state definitions for the memory stage
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_ctrl_decode.sv
// rtl/mem_ctrl_decode.sv - Combinational icode decode into access type and operand selects
module mem_ctrl_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_rd,
    output logic       o_wr,
    output logic       o_addr_sel_vala,
    output logic       o_wdata_sel_valp,
    output logic       o_ins,
    output logic       o_hlt
);

    always_comb begin
        o_rd             = 1'b0;
        o_wr             = 1'b0;
        o_addr_sel_vala  = 1'b0;
        o_wdata_sel_valp = 1'b0;
        o_ins            = 1'b0;
        o_hlt            = 1'b0;
        case (i_icode)
            ICODE_RMMOVQ, ICODE_PUSHQ: begin
                o_wr = 1'b1;
            end
            ICODE_CALL: begin
                o_wr             = 1'b1;
                o_wdata_sel_valp = 1'b1;
            end
            ICODE_MRMOVQ: begin
                o_rd = 1'b1;
            end
            // ret and popq read from the stack pointer carried in valA
            ICODE_RET, ICODE_POPQ: begin
                o_rd            = 1'b1;
                o_addr_sel_vala = 1'b1;
            end
            ICODE_HALT: begin
                o_hlt = 1'b1;
            end
            ICODE_NOP, ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ, ICODE_JXX: begin
                o_hlt = 1'b0;
            end
            default: begin
                o_ins = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86 memory stage FSM with bounds check, ack timeout; MEM_ALIGN_CHECK_EN adds alignment check
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] valM,
    output logic        busy,
    output logic        done,
    output logic [2:0]  stat
);

    localparam int              CW           = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LP_TIMEOUT   = CW'(TIMEOUT);
    localparam logic [64:0]     LP_MEM_BYTES = 65'(MEM_BYTES);

    state_t        r_state;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [63:0]   r_mem_addr;
    logic [63:0]   r_mem_wdata;
    logic [63:0]   r_valm;
    logic [2:0]    r_stat;
    logic [CW-1:0] r_cnt;

    logic          w_rd;
    logic          w_wr;
    logic          w_addr_sel_vala;
    logic          w_wdata_sel_valp;
    logic          w_ins;
    logic          w_hlt;
    logic          w_access;
    logic [63:0]   w_addr;
    logic [63:0]   w_wdata;
    logic [64:0]   w_addr_end;
    logic          w_oob;
    logic          w_bad_addr;
    logic [CW-1:0] w_cnt_inc;

    mem_ctrl_decode u_decode (
        .i_icode          (icode),
        .o_rd             (w_rd),
        .o_wr             (w_wr),
        .o_addr_sel_vala  (w_addr_sel_vala),
        .o_wdata_sel_valp (w_wdata_sel_valp),
        .o_ins            (w_ins),
        .o_hlt            (w_hlt)
    );

    assign w_access   = w_rd | w_wr;
    assign w_addr     = w_addr_sel_vala ? valA : valE;
    assign w_wdata    = w_wdata_sel_valp ? valP : valA;
    // One extra bit so addresses near 2^64 cannot wrap past the bound
    assign w_addr_end = {1'b0, w_addr} + 65'd8;
    assign w_oob      = w_addr_end > LP_MEM_BYTES;
`ifdef MEM_ALIGN_CHECK_EN
    assign w_bad_addr = w_oob | (w_addr[2:0] != 3'b000);
`else
    assign w_bad_addr = w_oob;
`endif
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_valm      <= '0;
            r_stat      <= STAT_AOK;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_ins) begin
                            r_stat  <= STAT_INS;
                            r_state <= ST_DONE;
                        end else if (!w_access) begin
                            r_stat  <= w_hlt ? STAT_HLT : STAT_AOK;
                            r_state <= ST_DONE;
                        end else if (w_bad_addr) begin
                            r_stat  <= STAT_ADR;
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_wr;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                            r_cnt       <= '0;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack arriving on the final wait cycle still completes normally
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_valm <= mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_stat    <= STAT_AOK;
                        r_state   <= ST_DONE;
                    end else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_cnt     <= w_cnt_inc;
                        r_mem_req <= 1'b0;
                        r_stat    <= STAT_ADR;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign valM      = r_valm;
    assign stat      = r_stat;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - Table-driven scoreboard bench for memory_stage
module tb_memory_stage;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [63:0] valp;
        logic [63:0] rdata;
        int          ack_at;
        int          exp_req;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [2:0]  exp_stat;
        logic [63:0] exp_valm;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [63:0] valM;
    logic        busy, done;
    logic [2:0]  stat;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[13];
    vec_t sb[$];

    memory_stage #(.MEM_BYTES(8192), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valM(valM),
        .busy(busy), .done(done), .stat(stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                                input logic [63:0] vp, input logic [63:0] rd, input int ack_at,
                                input int nreq, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [2:0] st,
                                input logic [63:0] vm, input int lat);
        vec_t v;
        v.icode = ic; v.vale = ve; v.vala = va; v.valp = vp; v.rdata = rd;
        v.ack_at = ack_at; v.exp_req = nreq; v.exp_we = we; v.exp_addr = addr;
        v.exp_wdata = wdata; v.exp_stat = st; v.exp_valm = vm; v.exp_lat = lat;
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        int   cyc;
        int   reqc;
        bit   seen;
        v = vecs[idx];
        cyc = 0; reqc = 0; seen = 0;
        @(negedge clk);
        icode = v.icode; valE = v.vale; valA = v.vala; valP = v.valp; start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        while (!seen && cyc < 40) begin
            cyc++;
            if (done) begin
                seen = 1;
                e = sb.pop_front();
                chk($sformatf("v%0d stat", idx), 64'(stat), 64'(e.exp_stat));
                chk($sformatf("v%0d valM", idx), valM, e.exp_valm);
                chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(e.exp_lat));
                chk($sformatf("v%0d req_cycles", idx), 64'(reqc), 64'(e.exp_req));
                chk($sformatf("v%0d req_at_done", idx), 64'(mem_req), 64'd0);
                mem_ack = 1'b0;
            end else begin
                chk($sformatf("v%0d busy", idx), 64'(busy), 64'd1);
                if (mem_req) begin
                    reqc++;
                    chk($sformatf("v%0d we", idx), 64'(mem_we), 64'(v.exp_we));
                    chk($sformatf("v%0d addr", idx), mem_addr, v.exp_addr);
                    if (v.exp_we) chk($sformatf("v%0d wdata", idx), mem_wdata, v.exp_wdata);
                    mem_ack   = (reqc == v.ack_at);
                    mem_rdata = mem_ack ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d done_timeout: no done within 40 cycles, expected done", idx);
            sb.delete();
            mem_ack = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d idle_after", idx), 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, " mem_addr"}, mem_addr, 64'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, " valM"}, valM, 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " stat"}, 64'(stat), 64'(AOK));
    endtask

    initial begin
        logic [63:0] vm_mis;
        rst = 1'b1; start = 1'b0; icode = 4'h1; valE = '0; valA = '0; valP = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        vecs[0]  = mk(4'h4, 64'h100, 64'hDEAD, 64'h0, 64'h5555, 3, 3, 1'b1, 64'h100, 64'hDEAD, AOK, 64'h0, 4);
        vecs[1]  = mk(4'hB, 64'h9000, 64'h200, 64'h0, 64'h1234, 1, 1, 1'b0, 64'h200, 64'h0, AOK, 64'h1234, 2);
        vecs[2]  = mk(4'h5, 64'd8190, 64'h0, 64'h0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0, ADR, 64'h1234, 1);
        vecs[3]  = mk(4'h8, 64'h300, 64'h11, 64'h55, 64'h6666, 0, 16, 1'b1, 64'h300, 64'h55, ADR, 64'h1234, 17);
        vecs[4]  = mk(4'h8, 64'h308, 64'h11, 64'h56, 64'h6666, 16, 16, 1'b1, 64'h308, 64'h56, AOK, 64'h1234, 17);
        vecs[5]  = mk(4'hE, 64'h100, 64'h0, 64'h0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0, INS, 64'h1234, 1);
        vecs[6]  = mk(4'h0, 64'h100, 64'h0, 64'h0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0, HLT, 64'h1234, 1);
        vecs[7]  = mk(4'h5, 64'd8184, 64'h0, 64'h0, 64'hCAFE, 2, 2, 1'b0, 64'd8184, 64'h0, AOK, 64'hCAFE, 3);
        vecs[8]  = mk(4'h9, 64'hFFFF_FFFF_FFFF_FFF0, 64'h40, 64'h0, 64'h77, 1, 1, 1'b0, 64'h40, 64'h0, AOK, 64'h77, 2);
        vecs[9]  = mk(4'hA, 64'h108, 64'hABC, 64'h999, 64'h8888, 1, 1, 1'b1, 64'h108, 64'hABC, AOK, 64'h77, 2);
`ifdef MEM_ALIGN_CHECK_EN
        vm_mis   = 64'h77;
        vecs[10] = mk(4'h5, 64'h103, 64'h0, 64'h0, 64'h3131, 1, 0, 1'b0, 64'h0, 64'h0, ADR, vm_mis, 1);
`else
        vm_mis   = 64'h3131;
        vecs[10] = mk(4'h5, 64'h103, 64'h0, 64'h0, 64'h3131, 1, 1, 1'b0, 64'h103, 64'h0, AOK, vm_mis, 2);
`endif
        vecs[11] = mk(4'h6, 64'h100, 64'h0, 64'h0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0, AOK, vm_mis, 1);
        vecs[12] = mk(4'hC, 64'h100, 64'h0, 64'h0, 64'h0, 1, 0, 1'b0, 64'h0, 64'h0, INS, vm_mis, 1);

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
        end

        // Reset in the middle of a request beats a simultaneous start and ack
        @(negedge clk);
        icode = 4'h8; valE = 64'h300; valP = 64'h99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_seq req1", 64'(mem_req), 64'd1);
        @(negedge clk);
        chk("rst_seq req2", 64'(mem_req), 64'd1);
        rst = 1'b1; start = 1'b1; icode = 4'h4; mem_ack = 1'b1; mem_rdata = 64'h7777;
        @(negedge clk);
        chk_reset_vals("rst_in_req");
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_seq no_done%0d", k), 64'(done), 64'd0);
            chk($sformatf("rst_seq no_req%0d", k), 64'(mem_req), 64'd0);
        end

        // A start pulse while busy must not disturb the request in flight
        @(negedge clk);
        icode = 4'h5; valE = 64'h80; start = 1'b1;
        @(negedge clk);
        chk("busy_seq req", 64'(mem_req), 64'd1);
        chk("busy_seq addr1", mem_addr, 64'h80);
        icode = 4'h4; valE = 64'h500; valA = 64'h1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_seq addr2", mem_addr, 64'h80);
        chk("busy_seq we2", 64'(mem_we), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h4242;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("busy_seq done", 64'(done), 64'd1);
        chk("busy_seq valM", valM, 64'h4242);
        chk("busy_seq stat", 64'(stat), 64'(AOK));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("busy_seq quiet_done%0d", k), 64'(done), 64'd0);
            chk($sformatf("busy_seq quiet_req%0d", k), 64'(mem_req), 64'd0);
        end
        chk("busy_seq stat_hold", 64'(stat), 64'(AOK));
        chk("busy_seq valM_hold", valM, 64'h4242);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
